// File: rtl/i2c_mem_slave_if.sv
// Memory-side and bus-control signals of the I2C memory slave.
// The open-drain SDA line stays a plain inout on the module.
interface i2c_mem_slave_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              scl;
    logic [7:0]        id;
    logic              mem_clk;
    logic              mem_ce;
    logic              mem_rden;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  scl, id, mem_rdata,
        output mem_clk, mem_ce, mem_rden, mem_wren, mem_addr, mem_wdata
    );

    modport master (
        output scl, id, mem_rdata,
        input  mem_clk, mem_ce, mem_rden, mem_wren, mem_addr, mem_wdata
    );
endinterface

// File: rtl/i2c_mem_slave.sv
// I2C-style slave: device ID + R/W, one address byte and one data byte per frame,
// bridged to a byte-wide synchronous memory. SCL/SDA are oversampled by clk8x.
module i2c_mem_slave #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic           clk8x,
    input  logic           reset,
    inout  wire            sda,
    i2c_mem_slave_if.slave bus
);
    localparam int unsigned ID_W  = 8;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = $clog2(DATA_W);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        DEV_ADDR   = 4'd1,
        RW         = 4'd2,
        ACK_DEV    = 4'd3,
        MEM_ADDR   = 4'd4,
        ACK_ADDR   = 4'd5,
        READ_DATA  = 4'd6,
        MASTER_ACK = 4'd7,
        WRITE_DATA = 4'd8,
        ACK_DATA   = 4'd9,
        WAIT       = 4'd10
    } state_e;

    state_e            state, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   dev_q, dev_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] mem_address_buffer, mem_address_buffer_d;
    logic [DATA_W-1:0] data_buffer, data_buffer_d;
    logic              oe_q, oe_d;
    logic              ce_q, ce_d;
    logic              rden_q, rden_d;
    logic              wren_q, wren_d;
    logic              rd_wait_q;

    logic [2:0]        scl_q, sda_q;
    logic              scl_rise, scl_fall, bus_start, bus_stop, sda_bit;
    logic [IDX_W-1:0]  rd_idx;

    // Two sync flops plus one history flop for edge detection; idle bus is high
    always_ff @(posedge clk8x) begin
        if (reset) begin
            scl_q <= '1;
            sda_q <= '1;
        end else begin
            scl_q <= {scl_q[1:0], bus.scl};
            sda_q <= {sda_q[1:0], sda};
        end
    end

    assign sda_bit   = sda_q[1];
    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign bus_start = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign bus_stop  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
    assign rd_idx    = IDX_W'(DATA_W - 1) - cnt_q[IDX_W-1:0];

    always_ff @(posedge clk8x) begin
        if (reset) begin
            state              <= IDLE;
            cnt_q              <= '0;
            dev_q              <= '0;
            rw_q               <= 1'b0;
            mem_address_buffer <= '0;
            data_buffer        <= '0;
            oe_q               <= 1'b0;
            ce_q               <= 1'b0;
            rden_q             <= 1'b0;
            wren_q             <= 1'b0;
            rd_wait_q          <= 1'b0;
        end else begin
            state              <= state_d;
            cnt_q              <= cnt_d;
            dev_q              <= dev_d;
            rw_q               <= rw_d;
            mem_address_buffer <= mem_address_buffer_d;
            data_buffer        <= data_buffer_d;
            oe_q               <= oe_d;
            ce_q               <= ce_d;
            rden_q             <= rden_d;
            wren_q             <= wren_d;
            rd_wait_q          <= rden_q;
        end
    end

    // Ack phases use oe_q as the half-bit marker: first fall drives low, second releases
    always_comb begin
        state_d              = state;
        cnt_d                = cnt_q;
        dev_d                = dev_q;
        rw_d                 = rw_q;
        mem_address_buffer_d = mem_address_buffer;
        data_buffer_d        = data_buffer;
        oe_d                 = oe_q;
        ce_d                 = 1'b0;
        rden_d               = 1'b0;
        wren_d               = 1'b0;

        if (rd_wait_q) data_buffer_d = bus.mem_rdata;

        if (bus_start) begin
            state_d = DEV_ADDR;
            cnt_d   = '0;
            oe_d    = 1'b0;
        end else if (bus_stop) begin
            state_d = IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
        end else begin
            case (state)
                IDLE: oe_d = 1'b0;
                DEV_ADDR: if (scl_rise) begin
                    dev_d = {dev_q[ID_W-2:0], sda_bit};
                    if (cnt_q == CNT_W'(ID_W - 1)) begin
                        state_d = RW;
                        cnt_d   = '0;
                    end else cnt_d = cnt_q + CNT_W'(1);
                end
                RW: if (scl_rise) begin
                    rw_d    = sda_bit;
                    state_d = (dev_q == bus.id) ? ACK_DEV : WAIT;
                end
                ACK_DEV: if (scl_fall) begin
                    if (!oe_q) oe_d = 1'b1;
                    else begin
                        oe_d    = 1'b0;
                        state_d = MEM_ADDR;
                    end
                end
                MEM_ADDR: if (scl_rise) begin
                    mem_address_buffer_d = {mem_address_buffer[ADDR_W-2:0], sda_bit};
                    if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                        state_d = ACK_ADDR;
                        cnt_d   = '0;
                        ce_d    = rw_q;
                        rden_d  = rw_q;
                    end else cnt_d = cnt_q + CNT_W'(1);
                end
                ACK_ADDR: if (scl_fall) begin
                    if (!oe_q) oe_d = 1'b1;
                    else if (rw_q) begin
                        state_d = READ_DATA;
                        oe_d    = ~data_buffer[DATA_W-1];
                        cnt_d   = '0;
                    end else begin
                        state_d = WRITE_DATA;
                        oe_d    = 1'b0;
                        cnt_d   = '0;
                    end
                end
                READ_DATA: begin
                    if (scl_rise) cnt_d = cnt_q + CNT_W'(1);
                    if (scl_fall) begin
                        if (cnt_q == CNT_W'(DATA_W)) begin
                            state_d = MASTER_ACK;
                            oe_d    = 1'b0;
                        end else oe_d = ~data_buffer[rd_idx];
                    end
                end
                MASTER_ACK: begin
                    oe_d = 1'b0;
                    if (scl_rise) state_d = WAIT;
                end
                WRITE_DATA: if (scl_rise) begin
                    data_buffer_d = {data_buffer[DATA_W-2:0], sda_bit};
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = ACK_DATA;
                        cnt_d   = '0;
                        ce_d    = 1'b1;
                        wren_d  = 1'b1;
                    end else cnt_d = cnt_q + CNT_W'(1);
                end
                ACK_DATA: if (scl_fall) begin
                    if (!oe_q) oe_d = 1'b1;
                    else begin
                        oe_d    = 1'b0;
                        state_d = WAIT;
                    end
                end
                WAIT:    oe_d = 1'b0;
                default: begin
                    state_d = IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    assign sda           = oe_q ? 1'b0 : 1'bz;
    assign bus.mem_clk   = clk8x;
    assign bus.mem_ce    = ce_q;
    assign bus.mem_rden  = rden_q;
    assign bus.mem_wren  = wren_q;
    assign bus.mem_addr  = mem_address_buffer;
    assign bus.mem_wdata = data_buffer;
endmodule

// File: tb/tb_i2c_mem_slave.sv
// Directed bench for i2c_mem_slave: a transaction table plus hand-built corner-case frames.
module tb_i2c_mem_slave;
    localparam int unsigned H = 6;
    localparam logic [3:0] S_IDLE = 4'd0, S_DEV = 4'd1, S_MEM = 4'd4, S_READ = 4'd6,
                           S_WRITE = 4'd8, S_WAIT = 4'd10;

    typedef struct packed {
        logic       rd;
        logic [7:0] dev;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       exp_ack;
        logic [7:0] exp_rdata;
        logic       stop_after;
    } vec_t;

    logic clk8x = 1'b0;
    logic reset = 1'b1;
    logic m_low = 1'b0;
    wire  sda;
    logic [3:0] st;

    i2c_mem_slave_if bus ();

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_mem_slave dut (
        .clk8x (clk8x),
        .reset (reset),
        .sda   (sda),
        .bus   (bus)
    );

    always #5 clk8x = ~clk8x;
    assign st = 4'(dut.state);

    // Synchronous memory model with mem[1] preloaded
    logic [7:0] mem [0:255];
    always @(posedge clk8x) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[1]        <= 8'h05;
            bus.mem_rdata <= 8'h00;
        end else begin
            if (bus.mem_ce && bus.mem_rden) bus.mem_rdata <= mem[bus.mem_addr];
            if (bus.mem_ce && bus.mem_wren) mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    int rden_cnt = 0, wren_cnt = 0, viol_cnt = 0, slave_drv = 0;
    logic [7:0] last_raddr = 8'h00, last_waddr = 8'h00, last_wdata = 8'h00;
    always @(negedge clk8x) begin
        if (bus.mem_ce && bus.mem_rden) begin
            rden_cnt   <= rden_cnt + 1;
            last_raddr <= bus.mem_addr;
        end
        if (bus.mem_ce && bus.mem_wren) begin
            wren_cnt   <= wren_cnt + 1;
            last_waddr <= bus.mem_addr;
            last_wdata <= bus.mem_wdata;
        end
        if ((bus.mem_rden && bus.mem_wren) || (bus.mem_ce != (bus.mem_rden | bus.mem_wren)) ||
            ((bus.mem_rden | bus.mem_wren) && (st == S_IDLE || st == S_WAIT)))
            viol_cnt <= viol_cnt + 1;
        if (!m_low && sda == 1'b0) slave_drv <= slave_drv + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk8x);
    endtask

    task automatic bus_start();
        m_low = 1'b0;
        if (!bus.scl) begin
            wait_cyc(H);
            bus.scl = 1'b1;
        end
        wait_cyc(H);
        m_low = 1'b1;
        wait_cyc(H);
        bus.scl = 1'b0;
        wait_cyc(H);
    endtask

    task automatic bus_stop();
        m_low = 1'b1;
        wait_cyc(H);
        bus.scl = 1'b1;
        wait_cyc(H);
        m_low = 1'b0;
        wait_cyc(H);
    endtask

    task automatic send_bit(input logic b);
        m_low = ~b;
        wait_cyc(H);
        bus.scl = 1'b1;
        wait_cyc(H);
        bus.scl = 1'b0;
        wait_cyc(1);
    endtask

    task automatic read_bit(output logic b);
        m_low = 1'b0;
        wait_cyc(H);
        bus.scl = 1'b1;
        wait_cyc(2);
        b = sda;
        wait_cyc(H - 2);
        bus.scl = 1'b0;
        wait_cyc(1);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic read_byte(output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs [8];
        vec_t v;
        logic ack;
        logic [7:0] rb;
        int r0, w0, d0;

        //           rd    dev    addr   wdata  nack  rdata  stop
        vecs[0] = '{1'b0, 8'h01, 8'h02, 8'h7F, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 8'h01, 8'h02, 8'h00, 1'b0, 8'h7F, 1'b1};
        vecs[2] = '{1'b1, 8'h01, 8'h01, 8'h00, 1'b0, 8'h05, 1'b1};
        vecs[3] = '{1'b1, 8'h03, 8'h01, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[4] = '{1'b0, 8'h01, 8'hFF, 8'hA5, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{1'b1, 8'h01, 8'hFF, 8'h00, 1'b0, 8'hA5, 1'b1};
        vecs[6] = '{1'b0, 8'h02, 8'h05, 8'h33, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{1'b1, 8'h01, 8'h05, 8'h00, 1'b0, 8'h00, 1'b1};

        bus.scl = 1'b1;
        bus.id  = 8'h01;
        wait_cyc(5);
        check("rst_state", 32'(st), 32'(S_IDLE));
        check("rst_sda", 32'(sda), 32'd1);
        check("rst_ce", 32'(bus.mem_ce), 32'd0);
        check("rst_rden", 32'(bus.mem_rden), 32'd0);
        check("rst_wren", 32'(bus.mem_wren), 32'd0);
        check("rst_addr_buf", 32'(dut.mem_address_buffer), 32'd0);
        check("rst_data_buf", 32'(dut.data_buffer), 32'd0);
        check("rst_cnt", 32'(dut.cnt_q), 32'd0);
        reset = 1'b0;
        wait_cyc(5);

        for (int i = 0; i < 8; i++) begin
            v  = vecs[i];
            r0 = rden_cnt;
            w0 = wren_cnt;
            d0 = slave_drv;
            bus_start();
            send_byte(v.dev);
            send_bit(v.rd);
            read_bit(ack);
            check("ack_dev", 32'(ack), 32'(v.exp_ack));
            send_byte(v.addr);
            if (v.exp_ack) begin
                wait_cyc(4);
                check("nomatch_wait", 32'(st), 32'(S_WAIT));
                check("nomatch_no_drive", 32'(slave_drv - d0), 32'd0);
                check("nomatch_no_strobe", 32'(rden_cnt + wren_cnt - r0 - w0), 32'd0);
            end else begin
                read_bit(ack);
                check("ack_addr", 32'(ack), 32'd0);
                if (v.rd) begin
                    read_byte(rb);
                    check("rdata", 32'(rb), 32'(v.exp_rdata));
                    send_bit(1'b1);
                    check("rden_pulses", 32'(rden_cnt - r0), 32'd1);
                    check("raddr", 32'(last_raddr), 32'(v.addr));
                    check("rd_no_wren", 32'(wren_cnt - w0), 32'd0);
                end else begin
                    send_byte(v.wdata);
                    read_bit(ack);
                    check("ack_data", 32'(ack), 32'd0);
                    check("wren_pulses", 32'(wren_cnt - w0), 32'd1);
                    check("waddr", 32'(last_waddr), 32'(v.addr));
                    check("wdata", 32'(last_wdata), 32'(v.wdata));
                    check("wr_no_rden", 32'(rden_cnt - r0), 32'd0);
                    check("mem_written", 32'(mem[v.addr]), 32'(v.wdata));
                end
                wait_cyc(4);
                check("post_wait", 32'(st), 32'(S_WAIT));
            end
            if (v.stop_after) begin
                bus_stop();
                check("post_stop_idle", 32'(st), 32'(S_IDLE));
            end
        end

        // Repeated START in the middle of the address byte
        r0 = rden_cnt;
        w0 = wren_cnt;
        bus_start();
        send_byte(8'h01);
        send_bit(1'b0);
        read_bit(ack);
        check("rs_ack_dev", 32'(ack), 32'd0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("rs_mid_addr", 32'(st), 32'(S_MEM));
        bus_start();
        check("rs_state", 32'(st), 32'(S_DEV));
        check("rs_cnt", 32'(dut.cnt_q), 32'd0);
        check("rs_no_access", 32'(rden_cnt + wren_cnt - r0 - w0), 32'd0);
        send_byte(8'h01);
        send_bit(1'b1);
        read_bit(ack);
        send_byte(8'h01);
        read_bit(ack);
        read_byte(rb);
        check("rs_recover_rdata", 32'(rb), 32'h05);
        send_bit(1'b1);
        bus_stop();

        // Reset while the write data byte is being shifted in
        w0 = wren_cnt;
        bus_start();
        send_byte(8'h01);
        send_bit(1'b0);
        read_bit(ack);
        send_byte(8'h10);
        read_bit(ack);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        check("rst_mid_write_state", 32'(st), 32'(S_WRITE));
        reset = 1'b1;
        wait_cyc(1);
        check("rst_mid_idle", 32'(st), 32'(S_IDLE));
        check("rst_mid_sda", 32'(sda), 32'd1);
        check("rst_mid_addr_buf", 32'(dut.mem_address_buffer), 32'd0);
        check("rst_mid_data_buf", 32'(dut.data_buffer), 32'd0);
        wait_cyc(2);
        reset = 1'b0;
        bus.scl = 1'b1;
        wait_cyc(3 * H);
        check("rst_mid_no_wren", 32'(wren_cnt - w0), 32'd0);
        check("rst_mid_still_idle", 32'(st), 32'(S_IDLE));

        // STOP while the slave is mid-way through a read byte (0x05: bit 2 is released)
        bus_start();
        send_byte(8'h01);
        send_bit(1'b1);
        read_bit(ack);
        send_byte(8'h01);
        read_bit(ack);
        rb = 8'hFF;
        for (int i = 7; i >= 3; i--) begin
            read_bit(ack);
            rb[i] = ack;
        end
        check("stop_rd_upper_bits", 32'(rb[7:3]), 32'd0);
        check("stop_rd_state", 32'(st), 32'(S_READ));
        m_low = 1'b1;
        wait_cyc(H);
        bus.scl = 1'b1;
        wait_cyc(H);
        m_low = 1'b0;
        wait_cyc(3);
        check("stop_rd_sda", 32'(sda), 32'd1);
        check("stop_rd_idle", 32'(st), 32'(S_IDLE));

        wait_cyc(4);
        check("strobe_rules", 32'(viol_cnt), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
